// File: rtl/booth_pkg.sv
// booth_pkg
//   Shared types and constants for the Booth multiplier issue front end.
//   state_t   : issue controller FSM states
//   MUL_W     : operand width
//   PROD_W    : product width
//   MUL_STEPS : Booth step cycles per multiply
//   OVF_MC    : multiplicand value the datapath cannot handle exactly
package booth_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPT} state_t;

  localparam int MUL_W     = 8;
  localparam int PROD_W    = 16;
  localparam int MUL_STEPS = 8;
  localparam int STEP_W    = $clog2(MUL_STEPS);

  localparam logic [MUL_W-1:0] OVF_MC = 8'h80;

  // The most negative multiplicand overflows the Booth accumulator when negated.
  function automatic logic is_ovf_mc(input logic [MUL_W-1:0] mc);
    return (mc == OVF_MC);
  endfunction

endpackage

// File: rtl/booth_op_fifo.sv
// booth_op_fifo
//   DEPTH-entry synchronous FIFO of {tag, mc, mp} operand records.
//   clk, rst   : clock, asynchronous active-high reset
//   push, din  : write request and record; ignored while full
//   pop        : read request; ignored while empty
//   head       : record at the read pointer (registered storage, no bypass)
//   empty,full : status flags
//   count      : number of stored records
module booth_op_fifo
  import booth_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [TAGW+2*MUL_W-1:0]     din,
  input  logic                        pop,
  output logic [TAGW+2*MUL_W-1:0]     head,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = TAGW + 2*MUL_W;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/booth_issue_ctrl.sv
// booth_issue_ctrl
//   Operand issue and result capture around an 8-bit signed Booth sequential
//   multiplier. Queues operand pairs, pulses mul_start, counts the Booth steps
//   and captures the product into a valid/ready output register.
//   clk, rst                     : clock, asynchronous active-high reset
//   in_valid/in_ready            : operand handshake (in_ready = !full)
//   in_mc, in_mp, in_tag         : signed operands and opaque tag
//   out_valid/out_ready          : result handshake
//   out_prod, out_tag, out_ovf   : product, its tag, multiplicand was 8'h80
//   mul_start, mul_mc, mul_mp    : multiplier load strobe and operands
//   mul_prod, mul_busy           : multiplier product and busy flag
//   err                          : sticky, multiplier still busy at capture
//   fifo_count                   : queued operand pairs
module booth_issue_ctrl
  import booth_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_mc,
  input  logic [7:0]             in_mp,
  input  logic [TAGW-1:0]        in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_prod,
  output logic [TAGW-1:0]        out_tag,
  output logic                   out_ovf,
  output logic                   mul_start,
  output logic [7:0]             mul_mc,
  output logic [7:0]             mul_mp,
  input  logic [15:0]            mul_prod,
  input  logic                   mul_busy,
  output logic                   err,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int EW = TAGW + 2*MUL_W;

  state_t            state;
  logic [STEP_W-1:0] step_cnt;
  logic [EW-1:0]     head;
  logic [TAGW-1:0]   head_tag;
  logic              fifo_empty;
  logic              fifo_full;
  logic [TAGW-1:0]   fl_tag;
  logic              fl_ovf;

  booth_op_fifo #(
    .DEPTH (DEPTH),
    .TAGW  (TAGW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .din   ({in_tag, in_mc, in_mp}),
    .pop   (state == LOAD),
    .head  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign in_ready = !fifo_full;
  assign head_tag = head[EW-1 -: TAGW];
  assign mul_mc   = head[2*MUL_W-1 -: MUL_W];
  assign mul_mp   = head[MUL_W-1:0];

  // Issue only when the result slot will be free by the capture edge, so a
  // CAPT reload never collides with an unconsumed product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      step_cnt  <= '0;
      mul_start <= 1'b0;
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_tag   <= '0;
      out_ovf   <= 1'b0;
      err       <= 1'b0;
      fl_tag    <= '0;
      fl_ovf    <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty && (!out_valid || out_ready)) begin
            state     <= LOAD;
            mul_start <= 1'b1;
          end
        end
        LOAD: begin
          mul_start <= 1'b0;
          fl_tag    <= head_tag;
          fl_ovf    <= is_ovf_mc(mul_mc);
          step_cnt  <= '0;
          state     <= RUN;
        end
        RUN: begin
          step_cnt <= step_cnt + 1'b1;
          if (step_cnt == STEP_W'(MUL_STEPS-1)) state <= CAPT;
        end
        CAPT: begin
          out_prod  <= mul_prod;
          out_tag   <= fl_tag;
          out_ovf   <= fl_ovf;
          out_valid <= 1'b1;
          if (mul_busy) err <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_issue_ctrl.sv
// tb_booth_issue_ctrl
//   Self-checking bench for booth_issue_ctrl with a radix-2 Booth sequential
//   multiplier core (no reset, free-running after its steps) wired to mul_*.
module tb_booth_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int TAGW  = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_mc;
  logic [7:0]  in_mp;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_prod;
  logic [3:0]  out_tag;
  logic        out_ovf;
  logic        mul_start;
  logic [7:0]  mul_mc;
  logic [7:0]  mul_mp;
  logic [15:0] mul_prod;
  logic        mul_busy;
  logic        err;
  logic [2:0]  fifo_count;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  booth_issue_ctrl #(
    .DEPTH (DEPTH),
    .TAGW  (TAGW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mc      (in_mc),
    .in_mp      (in_mp),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_prod   (out_prod),
    .out_tag    (out_tag),
    .out_ovf    (out_ovf),
    .mul_start  (mul_start),
    .mul_mc     (mul_mc),
    .mul_mp     (mul_mp),
    .mul_prod   (mul_prod),
    .mul_busy   (mul_busy),
    .err        (err),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Booth multiplier core: {A, Q, q-1} shifted arithmetically right each step.
  logic [7:0] b_a   = '0;
  logic [7:0] b_q   = '0;
  logic [7:0] b_m   = '0;
  logic       b_q1  = 1'b0;
  logic [3:0] b_cnt = '0;
  logic [7:0] b_sum;

  always_comb begin
    b_sum = b_a;
    case ({b_q[0], b_q1})
      2'b01:   b_sum = b_a + b_m;
      2'b10:   b_sum = b_a - b_m;
      default: b_sum = b_a;
    endcase
  end

  always @(posedge clk) begin
    if (mul_start) begin
      b_a   <= '0;
      b_q   <= mul_mp;
      b_q1  <= 1'b0;
      b_m   <= mul_mc;
      b_cnt <= 4'd8;
    end else if (b_cnt != 0) begin
      {b_a, b_q, b_q1} <= {b_sum[7], b_sum, b_q};
      b_cnt            <= b_cnt - 1'b1;
    end
  end

  assign mul_prod = {b_a, b_q};
  assign mul_busy = (b_cnt != 0);

  typedef struct {
    logic [7:0]  mc;
    logic [7:0]  mp;
    logic [3:0]  tag;
    logic [15:0] prod;
    logic        ovf;
  } vec_t;

  vec_t vecs[6];
  vec_t burst[5];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Offers one operand pair; returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic [7:0] mc, input logic [7:0] mp,
                               input logic [3:0] tag);
    int guard = 0;
    in_mc    = mc;
    in_mp    = mp;
    in_tag   = tag;
    in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitResult(output int edges);
    edges = 0;
    while (!out_valid && edges < 60) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int starts;
    int prev_cycle;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mc     = '0;
    in_mp     = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    vecs[0] = '{8'h03, 8'h05, 4'h1, 16'h000F, 1'b0};
    vecs[1] = '{8'hF9, 8'h06, 4'h2, 16'hFFD6, 1'b0};
    vecs[2] = '{8'hF8, 8'hF8, 4'h3, 16'h0040, 1'b0};
    vecs[3] = '{8'h7F, 8'h7F, 4'h4, 16'h3F01, 1'b0};
    vecs[4] = '{8'h81, 8'h7F, 4'h5, 16'hC0FF, 1'b0};
    vecs[5] = '{8'h01, 8'h80, 4'h6, 16'hFF80, 1'b0};

    burst[0] = '{8'h02, 8'h03, 4'h0, 16'h0006, 1'b0};
    burst[1] = '{8'hFF, 8'hFF, 4'h1, 16'h0001, 1'b0};
    burst[2] = '{8'h0A, 8'hF6, 4'h2, 16'hFF9C, 1'b0};
    burst[3] = '{8'h7F, 8'hFF, 4'h3, 16'hFF81, 1'b0};
    burst[4] = '{8'hFB, 8'h04, 4'h4, 16'hFFEC, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid",  32'(out_valid),  32'd0);
    checkOutput("rst_out_prod",   32'(out_prod),   32'd0);
    checkOutput("rst_out_tag",    32'(out_tag),    32'd0);
    checkOutput("rst_out_ovf",    32'(out_ovf),    32'd0);
    checkOutput("rst_mul_start",  32'(mul_start),  32'd0);
    checkOutput("rst_err",        32'(err),        32'd0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_in_ready",   32'(in_ready),   32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single operations: latency, product, tag and overflow flag.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].mc, vecs[i].mp, vecs[i].tag);
      waitResult(lat);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat),       32'd11);
      checkOutput($sformatf("vec%0d_prod", i),    32'(out_prod),  32'(vecs[i].prod));
      checkOutput($sformatf("vec%0d_tag", i),     32'(out_tag),   32'(vecs[i].tag));
      checkOutput($sformatf("vec%0d_ovf", i),     32'(out_ovf),   32'(vecs[i].ovf));
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_consumed", i), 32'(out_valid), 32'd0);
    end

    // Multiplicand 8'h80 raises out_ovf but is not an error.
    applyStimulus(8'h80, 8'h01, 4'hA);
    waitResult(lat);
    checkOutput("ovf_latency", 32'(lat),     32'd11);
    checkOutput("ovf_flag",    32'(out_ovf), 32'd1);
    checkOutput("ovf_tag",     32'(out_tag), 32'hA);
    checkOutput("ovf_err",     32'(err),     32'd0);
    @(posedge clk); #1;

    // Back-to-back burst: FIFO fills, results in order 11 cycles apart.
    fork
      begin
        for (int i = 0; i < 5; i++)
          applyStimulus(burst[i].mc, burst[i].mp, burst[i].tag);
        checkOutput("burst_count_full", 32'(fifo_count), 32'd4);
        checkOutput("burst_in_ready",   32'(in_ready),   32'd0);
      end
      begin
        prev_cycle = 0;
        for (int k = 0; k < 5; k++) begin
          int e;
          waitResult(e);
          checkOutput($sformatf("burst%0d_tag", k),  32'(out_tag),  32'(burst[k].tag));
          checkOutput($sformatf("burst%0d_prod", k), 32'(out_prod), 32'(burst[k].prod));
          if (k > 0)
            checkOutput($sformatf("burst%0d_spacing", k), 32'(cycle - prev_cycle), 32'd11);
          prev_cycle = cycle;
          @(posedge clk); #1;
        end
      end
    join

    // Back-pressure: first result held, no issue until it is consumed.
    out_ready = 1'b0;
    applyStimulus(8'h04, 8'h05, 4'h5);
    applyStimulus(8'hFD, 8'h03, 4'h6);
    waitResult(lat);
    checkOutput("hold_first_prod", 32'(out_prod), 32'h0014);
    checkOutput("hold_first_tag",  32'(out_tag),  32'h5);
    starts = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (mul_start) starts++;
    end
    checkOutput("hold_no_start",   32'(starts),     32'd0);
    checkOutput("hold_out_valid",  32'(out_valid),  32'd1);
    checkOutput("hold_prod_kept",  32'(out_prod),   32'h0014);
    checkOutput("hold_fifo_count", 32'(fifo_count), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("hold_release_start", 32'(mul_start), 32'd1);
    checkOutput("hold_release_valid", 32'(out_valid), 32'd0);
    waitResult(lat);
    checkOutput("hold_second_prod", 32'(out_prod), 32'hFFF7);
    checkOutput("hold_second_tag",  32'(out_tag),  32'h6);
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset during the 4th Booth step discards everything.
    applyStimulus(8'h09, 8'h09, 4'h7);
    applyStimulus(8'h02, 8'h03, 4'h8);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("midrun_fifo_count", 32'(fifo_count), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrun_rst_valid",    32'(out_valid),  32'd0);
    checkOutput("midrun_rst_count",    32'(fifo_count), 32'd0);
    checkOutput("midrun_rst_in_ready", 32'(in_ready),   32'd1);
    checkOutput("midrun_rst_start",    32'(mul_start),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(8'h02, 8'h02, 4'h9);
    waitResult(lat);
    checkOutput("post_rst_latency", 32'(lat),      32'd11);
    checkOutput("post_rst_prod",    32'(out_prod), 32'h0004);
    checkOutput("post_rst_tag",     32'(out_tag),  32'h9);
    checkOutput("post_rst_err",     32'(err),      32'd0);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_issue_ctrl.md
# booth_issue_ctrl

Operand-issue and result-capture front end for the 8-bit signed Booth sequential multiplier. Buffers incoming operand pairs in a small FIFO and drives the multiplier's start, multiplicand and multiplier inputs. Counts the eight Booth step cycles itself, captures the 16-bit product into a valid/ready output register, and flags the one multiplicand value the datapath cannot handle exactly. Sits directly upstream (operands) and downstream (product) of the multiplier core.

## Interface
- DEPTH, 4 — operand FIFO entries; power of 2, ≥2
- TAGW, 4 — width of the opaque tag carried alongside each operation
- clk in 1 — rising-edge clock
- rst in 1 — asynchronous, active-high reset
- in_valid in 1 — operand pair offered
- in_ready out 1 — FIFO can accept; equals !full
- in_mc in 8 — signed multiplicand
- in_mp in 8 — signed multiplier
- in_tag in TAGW — tag returned with the result
- out_valid out 1 — result register holds a product
- out_ready in 1 — consumer takes the result
- out_prod out 16 — signed product
- out_tag out TAGW — tag of out_prod
- out_ovf out 1 — set when the multiplicand was 8'h80
- mul_start out 1 — start/load strobe to the multiplier
- mul_mc out 8 — multiplicand to the multiplier; FIFO head
- mul_mp out 8 — multiplier operand; FIFO head
- mul_prod in 16 — multiplier product
- mul_busy in 1 — multiplier busy
- err out 1 — sticky; mul_busy was high in CAPT
- fifo_count out log2(DEPTH)+1 — stored entries

## Operation
- FIFO:
  - Push when in_valid && in_ready.
  - Pop only on the LOAD-cycle edge.
  - Simultaneous push and pop are legal; count is unchanged.
  - No bypass: a pushed entry is visible at the head one edge later.
  - When full, in_ready=0; no overwrite.
- FSM states IDLE, LOAD, RUN, CAPT:
  - IDLE→LOAD when the FIFO is non-empty && (!out_valid || out_ready). This guarantees the result slot is free before the capture edge.
  - LOAD: mul_start=1; mul_mc/mul_mp come from the head. At the edge the multiplier loads and the FIFO pops. The head's tag and ovf bit are latched into an in-flight register. Next state is RUN with step counter 0.
  - RUN: mul_start=0. Counter increments each edge; after the 8th RUN edge (count 7→done) go to CAPT.
  - CAPT: at the edge, load out_prod←mul_prod, out_tag, out_ovf and set out_valid=1. Set err if mul_busy==1. Next state is always IDLE.
- out_valid clears on an edge with out_ready=1 unless it is reloaded at that edge. Reload only happens from CAPT, and the issue rule guarantees the slot is free at that point.
- The multiplier has no reset and free-runs after its 8 steps. The controller never samples mul_prod outside CAPT and never relies on mul_busy for sequencing.
- out_ovf=1 iff the multiplicand is 8'h80. The product is still forwarded unchanged.
- mul_mc/mul_mp are driven from the FIFO head in every state; they are meaningful only in LOAD.
- Reset (asynchronous, any state), immediately:
  - FSM to IDLE, FIFO emptied, counter 0.
  - out_valid=0, out_prod=0, out_tag=0, out_ovf=0.
  - mul_start=0, err=0, fifo_count=0, in_ready=1.
- An operation in flight at reset is discarded; the next LOAD reinitialises the multiplier.

## Timing
- Idle, empty FIFO, operand accepted at edge E0:
  - IDLE at E1→LOAD.
  - mul_start high in cycle E1–E2.
  - RUN edges E3..E10.
  - CAPT edge E11.
  - out_valid high from E11.
- Latency is 11 edges from accept to out_valid.
- Sustained throughput with out_ready=1: one product per 11 cycles (CAPT→IDLE→LOAD).
- out_ready=0 while out_valid=1: no LOAD is issued; mul_start stays 0.
- mul_start is a single-cycle pulse, never asserted in consecutive cycles.

## Structure
- Shared package booth_pkg:
  - state enum {IDLE, LOAD, RUN, CAPT}
  - MUL_W=8, PROD_W=16, MUL_STEPS=8
  - OVF_MC=8'h80
- Sub-module booth_op_fifo: DEPTH-entry synchronous FIFO of {tag, mc, mp}, async reset, outputs head/empty/full/count.
- The FSM, counter and result register live in booth_issue_ctrl. The testbench instantiates the multiplier core beside it and wires mul_*.

## Test plan
- Reset, push mc=3 mp=5 tag=1, out_ready=1 → out_prod=16'h000F, tag 1, out_ovf=0, out_valid exactly 11 edges after accept.
- mc=8'hF9 (−7), mp=6 → out_prod=16'hFFD6 (−42); mc=−8, mp=−8 → 16'h0040.
- Push 5 ops (tags 0–4) back-to-back, out_ready=1 → in_ready drops when fifo_count=4; results in tag order, 11 cycles apart; all products correct.
- Two ops queued, out_ready=0 → first result held; mul_start stays 0 while held; out_ready=1 one cycle → second LOAD the next cycle, second result correct.
- mc=8'h80, mp=1 → out_valid with out_ovf=1; err=0.
- Assert rst mid-RUN (4th step) → out_valid=0, fifo_count=0, in_ready=1 immediately; then push 2×2 → out_prod=16'h0004, err=0.
